mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle combinational ALU. Implements the RISC-V M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage. The core stalls while ready_out is low.
- Iterative engine: shift-add multiply and restoring divide, one bit per cycle, with valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; legal values are even and >= 8.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  request strobe
- ready_out  output  1  unit can accept a request
- op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  input  WIDTH  rs1 operand
- b  input  WIDTH  rs2 operand
- valid_out  output  1  one-cycle result strobe
- result  output  WIDTH  result, held until the next accept
- busy  output  1  high in CALC, FIX and DONE

Behaviour:
- Clock and reset: one clock domain; asynchronous, active-high reset.
- Reset values: state=IDLE, ready_out=1, valid_out=0, busy=0, result=0, counter=0. Reset mid-operation aborts immediately; no result strobe is produced.
- Accept: on a rising edge where valid_in && ready_out. At that edge, latch op, a, b and the operand signs. ready_out is high only in IDLE.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on accept (normal case).
- IDLE -> DONE on accept for special divide cases, which bypass CALC and FIX:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - DIV with a=MIN_NEG, b=-1: gives MIN_NEG. REM for the same operands gives 0.
  - Special-case latency: valid_out is high in the cycle after the accept edge.
- CALC: runs exactly WIDTH cycles; counter counts 0..WIDTH-1, then the FSM moves to FIX.
  - Multiply: operates on magnitudes. Signedness per op: MULH both signed, MULHSU a signed / b unsigned, MULHU and MUL unsigned magnitudes. Each cycle, if multiplier LSB is 1, add multiplicand into the upper half of a 2*WIDTH accumulator, then shift right by one.
  - Divide: operates on magnitudes, signed for DIV/REM. Restoring divide: shift remainder:quotient left, trial-subtract divisor, keep the result if non-negative and set quotient LSB.
- FIX: one cycle.
  - Negate the product if the operand signs differ (signed ops only).
  - Negate the quotient if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - Select the result: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register result; FSM moves to DONE.
- DONE: valid_out=1 for exactly one cycle, then IDLE. A request cannot be accepted in DONE, since ready_out is low there.
- Normal latency: accept at edge 0, result valid in cycle WIDTH+2. With WIDTH=32 that is 34 cycles; throughput is one op per WIDTH+3 cycles.
- valid_in while busy is ignored; no queueing.
- Operands a and b may change after the accept edge without affecting the result.
- All arithmetic is two's complement, internal width WIDTH+1 to hold the MIN_NEG magnitude. Results wrap modulo 2^WIDTH.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - Multiply ops use a combinational signed (WIDTH+1)x(WIDTH+1) product.
  - They go IDLE -> FIX -> DONE, with valid_out two cycles after the accept edge.
  - Divide behaviour is unchanged.
- Undefined: all multiply ops use the iterative path.
- Results must be bit-identical in both builds.

Decomposition:
- Package mdu_pkg:
  - op localparams OP_MUL..OP_REMU.
  - state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - helper function is_signed_a(op).
- One sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: mode (mul/div), accumulator, operand.
  - Output: next accumulator.
  - Instantiated once; the top holds the FSM, counter and sign-fix logic.

Test Plan:
- Reset check: reset asserted mid-CALC of a DIVU -> next cycle ready_out=1, busy=0, valid_out=0 and stays 0.
- MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, valid_out at cycle 34.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- Signed divide with a=-7, b=2 -> DIV gives 0xFFFFFFFD (-3), REM gives 0xFFFFFFFF (-1). DIVU with a=100, b=7 gives 14; REMU gives 2.
- Divide by zero and overflow:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
  - All four produce valid_out one cycle after accept.
- Back-to-back handshake: valid_in held high continuously -> the second accept occurs exactly in the IDLE cycle after DONE; valid_in asserted during busy is not accepted; result stays stable between strobes.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM encoding and signedness helpers for mdu_iter
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one iteration of shift-add multiply or restoring divide
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_div,
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH+1:0] trial;

    // Multiply: acc = {carry:hi, lo=multiplier}; divide: acc = {rem(W+1), quotient(W)}
    always_comb begin
        sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shl   = {acc_in[2*WIDTH-1:0], 1'b0};
        trial = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, operand};
        if (mode_div) begin
            if (!trial[WIDTH+1]) begin
                acc_out = {trial[WIDTH:0], shl[WIDTH-1:1], 1'b1};
            end else begin
                acc_out = shl;
            end
        end else if (acc_in[0]) begin
            acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*WIDTH:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit; MDU_FAST_MUL_EN selects a single-cycle multiplier
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               sa, sb, b_zero, ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH:0]   step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

`ifdef MDU_FAST_MUL_EN
    logic signed [WIDTH:0]     fa, fb;
    logic signed [2*WIDTH-1:0] fprod;
    assign fa    = {is_signed_a(op) & a[WIDTH-1], a};
    assign fb    = {is_signed_b(op) & b[WIDTH-1], b};
    assign fprod = fa * fb;
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (op_q[2]),
        .acc_in   (acc_q),
        .operand  (opnd_q),
        .acc_out  (step_acc)
    );

    assign sa     = is_signed_a(op) & a[WIDTH-1];
    assign sb     = is_signed_b(op) & b[WIDTH-1];
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;
    assign b_zero = (b == '0);
    assign ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);

    // Sign flags are already qualified by op signedness, so unsigned ops never negate
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    op_d    = op;
                    neg_a_d = sa;
                    neg_b_d = sb;
                    cnt_d   = '0;
                    if (op[2] && (b_zero || ovf)) begin
                        if (b_zero) begin
                            result_d = op[1] ? a : '1;
                        end else begin
                            result_d = op[1] ? '0 : MIN_NEG;
                        end
                        state_d = S_DONE;
                    end else if (op[2]) begin
                        acc_d   = {{(WIDTH+1){1'b0}}, mag_a};
                        opnd_d  = mag_b;
                        state_d = S_CALC;
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        acc_d   = {1'b0, fprod};
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        state_d = S_FIX;
`else
                        acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
                        opnd_d  = mag_a;
                        state_d = S_CALC;
`endif
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign ready_out = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign valid_out = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter
module tb_mdu_iter;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        valid_out;
    logic [31:0] result;
    logic        busy;

    int tests_run = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    mdu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .op        (op),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint ux = {32'b0, x};
        longint uy = {32'b0, y};
        logic [63:0] p;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MINV && y == 32'hFFFF_FFFF) return MINV;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == MINV && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == MINV && y == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!o[2]) return 2;
`endif
        return W + 2;
    endfunction

    // Starts and ends on a falling edge; latency counts falling edges after the accept edge
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat, output bit to);
        int n = 0;
        while (!ready_out && n < 200) begin @(negedge clk); n++; end
        op = o; a = x; b = y; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        lat = 1;
        while (!valid_out && lat < 200) begin @(negedge clk); lat++; end
        to = !valid_out;
        r  = result;
    endtask

    task automatic test_reset();
        bit seen = 0;
        reset = 1'b1; valid_in = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests_run++; if (ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_out); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_out); end
        tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
        op = 3'd5; a = 32'd1000; b = 32'd3; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL midcalc_busy got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if (ready_out !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin
            fails++; $display("FAIL abort_state got rdy=%b busy=%b vld=%b want 1 0 0", ready_out, busy, valid_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (valid_out) seen = 1; end
        tests_run++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_strobe got %b want 0", seen); end
    endtask

    task automatic test_mul();
        logic [31:0] ta [4] = '{32'd7, MINV, MINV, MINV};
        logic [31:0] tb [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te [4] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] x, y, r, e;
        logic [2:0]  o;
        int lat, el;
        bit to;
        for (int i = 0; i < 8; i++) begin
            o = 3'(i % 4);
            if (i < 4) begin x = ta[i]; y = tb[i]; exp_q.push_back(te[i]); end
            else begin x = $urandom; y = $urandom; exp_q.push_back(ref_mdu(o, x, y)); end
            lat_q.push_back(exp_lat(o, x, y));
            run_op(o, x, y, r, lat, to);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            tests_run++;
            if (to) begin fails++; $display("FAIL mul[%0d] no valid_out within bound", i); end
            else if (r !== e) begin fails++; $display("FAIL mul[%0d] op=%0d result got %h want %h", i, o, r, e); end
            tests_run++;
            if (lat !== el) begin fails++; $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  to_ [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] tb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] te [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] x, y, r, e;
        logic [2:0]  o;
        int lat, el;
        bit to;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin o = to_[i]; x = ta[i]; y = tb[i]; exp_q.push_back(te[i]); end
            else begin
                o = 3'(4 + i % 4); x = $urandom; y = (i == 5) ? 32'($urandom_range(1, 255)) : $urandom;
                exp_q.push_back(ref_mdu(o, x, y));
            end
            lat_q.push_back(exp_lat(o, x, y));
            run_op(o, x, y, r, lat, to);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            tests_run++;
            if (to) begin fails++; $display("FAIL div[%0d] no valid_out within bound", i); end
            else if (r !== e) begin fails++; $display("FAIL div[%0d] op=%0d result got %h want %h", i, o, r, e); end
            tests_run++;
            if (lat !== el) begin fails++; $display("FAIL div[%0d] latency got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  to_ [5] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5};
        logic [31:0] ta [5] = '{32'd5, 32'd5, MINV, MINV, 32'd9};
        logic [31:0] tb [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] te [5] = '{32'hFFFF_FFFF, 32'd5, MINV, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] r, e;
        int lat, el;
        bit to;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(te[i]); lat_q.push_back(1);
            run_op(to_[i], ta[i], tb[i], r, lat, to);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            tests_run++;
            if (to) begin fails++; $display("FAIL special[%0d] no valid_out within bound", i); end
            else if (r !== e) begin fails++; $display("FAIL special[%0d] result got %h want %h", i, r, e); end
            tests_run++;
            if (lat !== el) begin fails++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_back_to_back();
        int acc_idx[$];
        int stb_idx[$];
        logic [31:0] e, first_res;
        bit stable = 1;
        while (!ready_out) @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd7; valid_in = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (ready_out && valid_in) begin
                acc_idx.push_back(i);
                exp_q.push_back(ref_mdu(op, a, b));
            end
            if (valid_out) begin
                stb_idx.push_back(i);
                e = exp_q.pop_front();
                tests_run++;
                if (result !== e) begin fails++; $display("FAIL b2b_result idx=%0d got %h want %h", i, result, e); end
            end
            if (i == 34) first_res = result;
            if (i > 34 && i <= 68 && result !== first_res) stable = 0;
            if (i == 1) a = 32'd100;
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (acc_idx.size() !== 2) begin fails++; $display("FAIL b2b_accepts got %0d want 2", acc_idx.size()); end
        else if (acc_idx[1] !== W + 3) begin fails++; $display("FAIL b2b_second_accept got %0d want %0d", acc_idx[1], W + 3); end
        tests_run++;
        if (stb_idx.size() !== 2) begin fails++; $display("FAIL b2b_strobes got %0d want 2", stb_idx.size()); end
        else if (stb_idx[0] !== W + 2 || stb_idx[1] !== 2 * W + 5) begin
            fails++; $display("FAIL b2b_strobe_idx got %0d,%0d want %0d,%0d", stb_idx[0], stb_idx[1], W + 2, 2 * W + 5);
        end
        tests_run++;
        if (stable !== 1'b1) begin fails++; $display("FAIL b2b_result_hold got %b want 1", stable); end
        tests_run++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL b2b_scoreboard_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
